// File: rtl/secp256k1_cmd_arb_if.sv
// AXI-stream style handshake bundle shared by all arbiter ports.
// mod carries the count of valid bytes on the eop beat.
interface if_axi_stream #(
    parameter int unsigned DAT_BYTS = 8
) ();
    localparam int unsigned ModW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic [DAT_BYTS*8-1:0] dat;
    logic                  val;
    logic                  rdy;
    logic                  sop;
    logic                  eop;
    logic                  err;
    logic [ModW-1:0]       mod;

    modport master (output dat, val, sop, eop, err, mod, input rdy);
    modport slave  (input dat, val, sop, eop, err, mod, output rdy);
endinterface

// File: rtl/secp256k1_cmd_arb.sv
// Packet-level round-robin arbiter sharing one secp256k1 command port; replies are routed back
// through an in-order tag FIFO. Define SECP256K1_CMD_ARB_STATS_EN for per-requester counters.
module secp256k1_cmd_arb #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DAT_BYTS        = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    if_axi_stream.slave                          if_req_rx [NUM_REQ],
    if_axi_stream.master                         if_req_tx [NUM_REQ],
    if_axi_stream.master                         if_core_tx,
    if_axi_stream.slave                          if_core_rx,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
    output logic                                 o_orphan
`ifdef SECP256K1_CMD_ARB_STATS_EN
    ,
    output logic [31:0]                          o_cmd_cnt [NUM_REQ],
    output logic [31:0]                          o_rpl_cnt [NUM_REQ]
`endif
);

    localparam int unsigned DatW = DAT_BYTS * 8;
    localparam int unsigned ModW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
    localparam int unsigned GW   = $clog2(NUM_REQ);
    localparam int unsigned AW   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {CIdle, CFwd} cmd_st_e;
    typedef enum logic [0:0] {RIdle, RFwd} rpl_st_e;

    // Requester-side signals flattened so they can be indexed by the registered grant/tag.
    logic [NUM_REQ-1:0] rx_val, rx_sop, rx_eop, rx_err, rx_rdy;
    logic [DatW-1:0]    rx_dat [NUM_REQ];
    logic [ModW-1:0]    rx_mod [NUM_REQ];
    logic [NUM_REQ-1:0] tx_val, tx_rdy;

    logic            ctx_val, ctx_sop, ctx_eop, ctx_err, ctx_rdy;
    logic [DatW-1:0] ctx_dat;
    logic [ModW-1:0] ctx_mod;
    logic            crx_rdy;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign rx_val[g]          = if_req_rx[g].val;
        assign rx_sop[g]          = if_req_rx[g].sop;
        assign rx_eop[g]          = if_req_rx[g].eop;
        assign rx_err[g]          = if_req_rx[g].err;
        assign rx_dat[g]          = if_req_rx[g].dat;
        assign rx_mod[g]          = if_req_rx[g].mod;
        assign if_req_rx[g].rdy   = rx_rdy[g];

        // Reply payload is broadcast; only the owner's val is raised.
        assign if_req_tx[g].val   = tx_val[g];
        assign if_req_tx[g].dat   = if_core_rx.dat;
        assign if_req_tx[g].sop   = if_core_rx.sop;
        assign if_req_tx[g].eop   = if_core_rx.eop;
        assign if_req_tx[g].err   = if_core_rx.err;
        assign if_req_tx[g].mod   = if_core_rx.mod;
        assign tx_rdy[g]          = if_req_tx[g].rdy;
    end

    assign if_core_tx.val = ctx_val;
    assign if_core_tx.dat = ctx_dat;
    assign if_core_tx.sop = ctx_sop;
    assign if_core_tx.eop = ctx_eop;
    assign if_core_tx.err = ctx_err;
    assign if_core_tx.mod = ctx_mod;
    assign ctx_rdy        = if_core_tx.rdy;
    assign if_core_rx.rdy = crx_rdy;

    cmd_st_e         cmd_q, cmd_d;
    rpl_st_e         rpl_q, rpl_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   tag_q, tag_d;
    logic [GW-1:0]   tag_mem_q [MAX_OUTSTANDING];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            orphan_q, orphan_d;

    logic            run, push, pop, full, empty, found;
    logic [GW-1:0]   pick;
    int unsigned     idx;

    // Outputs stay quiet while reset is being sampled so no handshake can slip through.
    assign run   = ~i_rst;
    assign full  = (count_q == CW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Round-robin search starts at ptr_q, the requester after the last one granted.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && rx_val[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        cmd_d   = cmd_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        push    = 1'b0;
        rx_rdy  = '0;
        ctx_val = 1'b0;
        ctx_sop = 1'b0;
        ctx_eop = 1'b0;
        ctx_err = 1'b0;
        ctx_dat = '0;
        ctx_mod = '0;
        unique case (cmd_q)
            CIdle: begin
                if (run && found && !full) begin
                    grant_d = pick;
                    cmd_d   = CFwd;
                end
            end
            CFwd: begin
                ctx_val         = run & rx_val[grant_q];
                ctx_sop         = rx_sop[grant_q];
                ctx_eop         = rx_eop[grant_q];
                ctx_err         = rx_err[grant_q];
                ctx_dat         = rx_dat[grant_q];
                ctx_mod         = rx_mod[grant_q];
                rx_rdy[grant_q] = run & ctx_rdy;
                if (ctx_val && ctx_rdy && ctx_eop) begin
                    push  = 1'b1;
                    cmd_d = CIdle;
                    ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: cmd_d = CIdle;
        endcase
    end

    always_comb begin
        rpl_d    = rpl_q;
        tag_d    = tag_q;
        pop      = 1'b0;
        orphan_d = 1'b0;
        crx_rdy  = 1'b0;
        tx_val   = '0;
        unique case (rpl_q)
            RIdle: begin
                if (run && if_core_rx.val) begin
                    if (!empty) begin
                        tag_d = tag_mem_q[rd_ptr_q];
                        rpl_d = RFwd;
                    end else begin
                        // No owner on record: swallow the packet and flag it once at its end.
                        crx_rdy  = 1'b1;
                        orphan_d = if_core_rx.eop;
                    end
                end
            end
            RFwd: begin
                tx_val[tag_q] = run & if_core_rx.val;
                crx_rdy       = run & tx_rdy[tag_q];
                if (if_core_rx.val && crx_rdy && if_core_rx.eop) begin
                    pop   = 1'b1;
                    rpl_d = RIdle;
                end
            end
            default: rpl_d = RIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q    <= CIdle;
            rpl_q    <= RIdle;
            grant_q  <= '0;
            ptr_q    <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            rpl_q    <= rpl_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_q;
        end
    end

    assign o_outstanding = count_q;
    assign o_orphan      = orphan_q;

`ifdef SECP256K1_CMD_ARB_STATS_EN
    logic [31:0] cmd_cnt_q [NUM_REQ];
    logic [31:0] cmd_cnt_d [NUM_REQ];
    logic [31:0] rpl_cnt_q [NUM_REQ];
    logic [31:0] rpl_cnt_d [NUM_REQ];

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        rpl_cnt_d = rpl_cnt_q;
        if (push) begin
            cmd_cnt_d[grant_q] = cmd_cnt_q[grant_q] + 32'd1;
        end
        if (pop) begin
            rpl_cnt_d[tag_q] = rpl_cnt_q[tag_q] + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cmd_cnt_q[i] <= '0;
                rpl_cnt_q[i] <= '0;
            end
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            rpl_cnt_q <= rpl_cnt_d;
        end
    end

    assign o_cmd_cnt = cmd_cnt_q;
    assign o_rpl_cnt = rpl_cnt_q;
`endif

endmodule

// File: tb/tb_secp256k1_cmd_arb.sv
// Directed bench for secp256k1_cmd_arb: requester/core stubs driven from queues, checks by
// immediate assertions against hand-built packets.
module tb_secp256k1_cmd_arb;

    localparam int NR = 2;
    localparam int MO = 4;
    localparam int DB = 8;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [63:0] dat;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BYTS(DB)) req_rx [NR] ();
    if_axi_stream #(.DAT_BYTS(DB)) req_tx [NR] ();
    if_axi_stream #(.DAT_BYTS(DB)) core_tx ();
    if_axi_stream #(.DAT_BYTS(DB)) core_rx ();

    logic [2:0] outstanding;
    logic       orphan;
`ifdef SECP256K1_CMD_ARB_STATS_EN
    logic [31:0] cmd_cnt [NR];
    logic [31:0] rpl_cnt [NR];
`endif

    secp256k1_cmd_arb #(
        .NUM_REQ        (NR),
        .MAX_OUTSTANDING(MO),
        .DAT_BYTS       (DB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .if_req_rx    (req_rx),
        .if_req_tx    (req_tx),
        .if_core_tx   (core_tx),
        .if_core_rx   (core_rx),
        .o_outstanding(outstanding),
        .o_orphan     (orphan)
`ifdef SECP256K1_CMD_ARB_STATS_EN
        ,
        .o_cmd_cnt    (cmd_cnt),
        .o_rpl_cnt    (rpl_cnt)
`endif
    );

    logic  rq_val [NR];
    beat_t rq_beat [NR];
    logic  rq_rdy [NR];
    logic  tx_val [NR];
    beat_t tx_beat [NR];
    logic  tx_rdy [NR];
    logic  ct_val, core_rdy, cr_val, cr_rdy;
    beat_t ct_beat, cr_beat;

    for (genvar g = 0; g < NR; g++) begin : g_port
        assign req_rx[g].val = rq_val[g];
        assign req_rx[g].sop = rq_beat[g].sop;
        assign req_rx[g].eop = rq_beat[g].eop;
        assign req_rx[g].err = rq_beat[g].err;
        assign req_rx[g].mod = rq_beat[g].mod;
        assign req_rx[g].dat = rq_beat[g].dat;
        assign rq_rdy[g]     = req_rx[g].rdy;
        assign tx_val[g]     = req_tx[g].val;
        assign tx_beat[g]    = {req_tx[g].sop, req_tx[g].eop, req_tx[g].err, req_tx[g].mod,
                                req_tx[g].dat};
        assign req_tx[g].rdy = tx_rdy[g];
    end

    assign ct_val      = core_tx.val;
    assign ct_beat     = {core_tx.sop, core_tx.eop, core_tx.err, core_tx.mod, core_tx.dat};
    assign core_tx.rdy = core_rdy;
    assign core_rx.val = cr_val;
    assign core_rx.sop = cr_beat.sop;
    assign core_rx.eop = cr_beat.eop;
    assign core_rx.err = cr_beat.err;
    assign core_rx.mod = cr_beat.mod;
    assign core_rx.dat = cr_beat.dat;
    assign cr_rdy      = core_rx.rdy;

    beat_t rq_q [NR][$];
    beat_t cr_q [$];
    beat_t core_log [$];
    beat_t tx_log [NR][$];
    int    orphan_cnt = 0;
    int    txval_cnt  = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    bit    hs [NR];
    bit    chs;

    // Source stubs: present queue heads, pop on handshake.
    initial begin
        for (int i = 0; i < NR; i++) begin
            rq_val[i]  = 1'b0;
            rq_beat[i] = '0;
        end
        cr_val  = 1'b0;
        cr_beat = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) hs[i] = rq_val[i] && rq_rdy[i];
            chs = cr_val && cr_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) void'(rq_q[i].pop_front());
                rq_val[i]  = (rq_q[i].size() > 0);
                rq_beat[i] = rq_val[i] ? rq_q[i][0] : '0;
            end
            if (chs) void'(cr_q.pop_front());
            cr_val  = (cr_q.size() > 0);
            cr_beat = cr_val ? cr_q[0] : '0;
        end
    end

    always @(negedge clk) begin
        if (ct_val && core_rdy) core_log.push_back(ct_beat);
        for (int i = 0; i < NR; i++) begin
            if (tx_val[i] && tx_rdy[i]) tx_log[i].push_back(tx_beat[i]);
        end
        if (tx_val[0] || tx_val[1]) txval_cnt++;
        if (orphan) orphan_cnt++;
    end

    function automatic beat_t mk(bit s, bit e, bit r, logic [2:0] m, logic [63:0] d);
        return {s, e, r, m, d};
    endfunction

    function automatic beat_t cmd_beat(int r, int idx, int b);
        if (b == 0) return mk(1'b1, 1'b0, 1'b0, 3'd0, {8'hC5, 8'(r), 8'(idx), 40'h0});
        return mk(1'b0, 1'b1, 1'b0, 3'd4, {8'hD5, 8'(r), 8'(idx), 40'h1});
    endfunction

    function automatic beat_t rpl_beat(int idx, int b, bit e);
        if (b == 0) return mk(1'b1, 1'b0, 1'b0, 3'd0, {8'hE5, 8'(idx), 48'h0});
        return mk(1'b0, 1'b1, e, 3'd2, {8'hF5, 8'(idx), 48'h0});
    endfunction

    task automatic add_cmd(input int r, input int idx);
        rq_q[r].push_back(cmd_beat(r, idx, 0));
        rq_q[r].push_back(cmd_beat(r, idx, 1));
    endtask

    task automatic add_rpl(input int idx, input bit e);
        cr_q.push_back(rpl_beat(idx, 0, 1'b0));
        cr_q.push_back(rpl_beat(idx, 1, e));
    endtask

    task automatic chk(input string tag, input beat_t obs, input beat_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_core(input int n, input string tag);
        for (int k = 0; k < 2000; k++) begin
            if (core_log.size() >= n) break;
            @(posedge clk);
            #1;
        end
        chki(tag, core_log.size(), n);
    endtask

    task automatic wait_tx(input int i, input int n, input string tag);
        for (int k = 0; k < 2000; k++) begin
            if (tx_log[i].size() >= n) break;
            @(posedge clk);
            #1;
        end
        chki(tag, tx_log[i].size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t t1c [3];
        beat_t t1r [2];
        int    cb, b0, b1, oc, vc;

        core_rdy = 1'b1;
        for (int i = 0; i < NR; i++) tx_rdy[i] = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chki("rst_core_val", int'(ct_val), 0);
        chki("rst_rx0_rdy", int'(rq_rdy[0]), 0);
        chki("rst_rx1_rdy", int'(rq_rdy[1]), 0);
        chki("rst_tx_val", int'(tx_val[0] | tx_val[1]), 0);
        chki("rst_core_rx_rdy", int'(cr_rdy), 0);
        chki("rst_outstanding", int'(outstanding), 0);
        chki("rst_orphan", int'(orphan), 0);

        // Both requesters contend from reset; core holds replies until the FIFO fills.
        for (int p = 0; p < 3; p++) begin
            add_cmd(0, 10 + 2 * p);
            add_cmd(1, 11 + 2 * p);
        end
        wait_core(8, "t2_fill");
        repeat (100) @(posedge clk);
        #1;
        chki("t2_stalled_beats", core_log.size(), 8);
        chki("t2_outstanding_full", int'(outstanding), 4);
        chki("t2_rx0_rdy_blocked", int'(rq_rdy[0]), 0);
        chki("t2_rx1_rdy_blocked", int'(rq_rdy[1]), 0);
        for (int p = 10; p < 14; p++) add_rpl(p, 1'b0);
        wait_core(12, "t2_rest");
        add_rpl(14, 1'b0);
        add_rpl(15, 1'b1);
        wait_tx(0, 6, "t2_tx0_cnt");
        wait_tx(1, 6, "t2_tx1_cnt");
        for (int p = 0; p < 6; p++) begin
            chki($sformatf("t2_owner%0d", p), int'(core_log[2 * p].dat[55:48]), p % 2);
            chk($sformatf("t2_cmd%0d", p), core_log[2 * p + 1], cmd_beat(p % 2, 10 + p, 1));
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t2_r0_%0d", j), tx_log[0][2 * j], rpl_beat(10 + 2 * j, 0, 1'b0));
            chk($sformatf("t2_r1_%0d", j), tx_log[1][2 * j + 1],
                rpl_beat(11 + 2 * j, 1, (j == 2)));
        end
        chki("t2_outstanding_end", int'(outstanding), 0);

        // Single requester 0, multi-beat command with fixed hash words.
        t1c[0] = mk(1'b1, 1'b0, 1'b0, 3'd0, 64'h4c7d_1a2b_0000_0001);
        t1c[1] = mk(1'b0, 1'b0, 1'b0, 3'd0, 64'h0123_4567_89ab_cdef);
        t1c[2] = mk(1'b0, 1'b1, 1'b0, 3'd5, 64'h3c4d_5e6f_a0b1_7fd4);
        t1r[0] = mk(1'b1, 1'b0, 1'b0, 3'd0, 64'h0000_0000_0000_0001);
        t1r[1] = mk(1'b0, 1'b1, 1'b0, 3'd1, 64'h0000_0000_0000_0000);
        cb = core_log.size();
        b0 = tx_log[0].size();
        b1 = tx_log[1].size();
        for (int k = 0; k < 3; k++) rq_q[0].push_back(t1c[k]);
        wait_core(cb + 3, "t1_fwd");
        for (int k = 0; k < 3; k++) chk($sformatf("t1_cmd%0d", k), core_log[cb + k], t1c[k]);
        chki("t1_out_after_cmd", int'(outstanding), 1);
        cr_q.push_back(t1r[0]);
        cr_q.push_back(t1r[1]);
        wait_tx(0, b0 + 2, "t1_rpl");
        chk("t1_rpl0", tx_log[0][b0], t1r[0]);
        chk("t1_rpl1", tx_log[0][b0 + 1], t1r[1]);
        chki("t1_no_tx1", tx_log[1].size(), b1);
        chki("t1_out_after_rpl", int'(outstanding), 0);

        // Reply for requester 1 stalled at its port blocks the reply for requester 0 behind it.
        cb = core_log.size();
        b0 = tx_log[0].size();
        b1 = tx_log[1].size();
        add_cmd(1, 20);
        wait_core(cb + 2, "t4_cmd20");
        add_cmd(0, 21);
        wait_core(cb + 4, "t4_cmd21");
        tx_rdy[1] = 1'b0;
        add_rpl(20, 1'b0);
        add_rpl(21, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chki("t4_tx0_blocked", tx_log[0].size(), b0);
        chki("t4_tx1_blocked", tx_log[1].size(), b1);
        chki("t4_tx1_val", int'(tx_val[1]), 1);
        chki("t4_core_rx_rdy", int'(cr_rdy), 0);
        chki("t4_outstanding", int'(outstanding), 2);
        tx_rdy[1] = 1'b1;
        wait_tx(1, b1 + 2, "t4_tx1_done");
        wait_tx(0, b0 + 2, "t4_tx0_done");
        repeat (10) @(posedge clk);
        #1;
        chki("t4_tx1_nodup", tx_log[1].size(), b1 + 2);
        chki("t4_tx0_nodup", tx_log[0].size(), b0 + 2);
        chk("t4_tx1_b0", tx_log[1][b1], rpl_beat(20, 0, 1'b0));
        chk("t4_tx1_b1", tx_log[1][b1 + 1], rpl_beat(20, 1, 1'b0));
        chk("t4_tx0_b0", tx_log[0][b0], rpl_beat(21, 0, 1'b0));
        chk("t4_tx0_b1", tx_log[0][b0 + 1], rpl_beat(21, 1, 1'b0));
        chki("t4_outstanding_end", int'(outstanding), 0);

        // Reply with nothing outstanding is drained and flagged once.
        oc = orphan_cnt;
        vc = txval_cnt;
        cr_q.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 64'h0063_0000_0000_0000));
        cr_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 64'h0063_0000_0000_0001));
        cr_q.push_back(mk(1'b0, 1'b1, 1'b0, 3'd3, 64'h0063_0000_0000_0002));
        repeat (12) @(posedge clk);
        #1;
        chki("t5_drained", cr_q.size(), 0);
        chki("t5_orphan_pulses", orphan_cnt - oc, 1);
        chki("t5_no_tx_val", txval_cnt - vc, 0);
        chki("t5_outstanding", int'(outstanding), 0);

        // Reset while forwarding with two commands outstanding.
        cb = core_log.size();
        add_cmd(0, 30);
        add_cmd(1, 31);
        wait_core(cb + 4, "t6_two_out");
        chki("t6_outstanding2", int'(outstanding), 2);
        core_rdy = 1'b0;
        cb = core_log.size();
        add_cmd(1, 32);
        repeat (5) @(posedge clk);
        #1;
        chki("t6_fwd_stalled", int'(ct_val), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chki("t6_core_val", int'(ct_val), 0);
        chki("t6_rx0_rdy", int'(rq_rdy[0]), 0);
        chki("t6_rx1_rdy", int'(rq_rdy[1]), 0);
        chki("t6_tx_val", int'(tx_val[0] | tx_val[1]), 0);
        chki("t6_core_rx_rdy", int'(cr_rdy), 0);
        chki("t6_outstanding0", int'(outstanding), 0);
        core_rdy = 1'b1;
        wait_core(cb + 2, "t6_regrant");
        chk("t6_cmd_b0", core_log[cb], cmd_beat(1, 32, 0));
        chk("t6_cmd_b1", core_log[cb + 1], cmd_beat(1, 32, 1));
        chki("t6_outstanding1", int'(outstanding), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/secp256k1_cmd_arb.md
Name: secp256k1_cmd_arb

Overview:
- Packet-level round-robin arbiter that shares one secp256k1_top command port between NUM_REQ requesters (host PCIe path, on-chip block verifier, etc.).
- Forwards whole VERIFY_SECP256K1_SIG command packets to the core and records the owning requester in a tag FIFO.
- Routes each reply packet (VERIFY_SECP256K1_SIG_RPL) back to its owner. The core returns replies strictly in command order.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- MAX_OUTSTANDING, 4, tag FIFO depth; maximum commands in flight to the core (power of 2).
- DAT_BYTS, 8, AXI-stream data bytes on all ports.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- if_req_rx[NUM_REQ]  in (if_axi_stream slave)  DAT_BYTS*8 data + val/rdy/sop/eop/err/mod  command packets from requesters.
- if_req_tx[NUM_REQ]  out (if_axi_stream master)  same  reply packets to requesters.
- if_core_tx  out (if_axi_stream master)  same  commands to secp256k1_top if_cmd_rx.
- if_core_rx  in (if_axi_stream slave)  same  replies from secp256k1_top if_cmd_tx.
- o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  commands sent, reply not yet completed.
- o_orphan  out  1  one-cycle pulse: reply eop received while tag FIFO empty.

Behaviour:
- Reset: all val outputs 0, all rdy outputs 0, o_outstanding 0, o_orphan 0, tag FIFO empty, RR pointer 0, both FSMs idle. Reset mid-packet abandons the packet; no partial state survives.
- Command FSM states: C_IDLE, C_FWD.
- C_IDLE: if any if_req_rx[i].val and FIFO not full, grant the first requester at or after (last_grant+1) mod NUM_REQ. Register grant, go to C_FWD. If the FIFO is full, no grant. Granting costs 1 bubble cycle.
- C_FWD: if_core_tx carries all signals of the granted rx combinationally. if_req_rx[grant].rdy = if_core_tx.rdy; other rx rdy = 0.
- On val&rdy&eop in C_FWD: push grant into the tag FIFO, set last_grant = grant, return to C_IDLE. A packet is never interleaved with another requester.
- Single-beat packet (sop&eop): same rule.
- Reply FSM states: R_IDLE, R_FWD.
- R_IDLE: if if_core_rx.val and FIFO not empty, latch tag = FIFO head, go to R_FWD. If the FIFO is empty, set if_core_rx.rdy=1 (drain). On eop, pulse o_orphan and stay in R_IDLE.
- R_FWD: if_req_tx[tag] mirrors if_core_rx; if_core_rx.rdy = if_req_tx[tag].rdy; other tx val = 0.
- On val&rdy&eop in R_FWD: pop the FIFO, go to R_IDLE.
- Push and pop in the same cycle are both performed; o_outstanding is unchanged.
- o_outstanding = FIFO occupancy, registered, updated the cycle after the push/pop.
- Backpressure on one requester's reply blocks all replies (in-order core). The command path continues until the FIFO is full.
- err on any beat is forwarded unchanged; the arbiter never inspects payload.

Optional Feature:
- Macro SECP256K1_CMD_ARB_STATS_EN.
- Defined:
  - Adds output o_cmd_cnt[NUM_REQ] (32 bits each): commands granted per requester, incremented on command eop handshake.
  - Adds output o_rpl_cnt[NUM_REQ] (32 bits each): replies delivered per requester.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
- Single requester 0 sends command index 1 (hash 4c7d…7fd4, valid sig). Required: core receives identical packet; reply with bm=0, index=1 appears only on if_req_tx[0]; o_outstanding goes 0→1→0.
- Requesters 0 and 1 both assert val in the same cycle, 3 packets each, core stubbed to reply after 100 cycles. Required: core order 0,1,0,1,0,1; each reply index is delivered to its originating port.
- MAX_OUTSTANDING=4, stub core never replies, 6 commands queued. Required: exactly 4 forwarded; o_outstanding=4; 5th requester rdy stays 0 until one reply completes.
- Hold if_req_tx[1].rdy=0 while a reply for requester 1 is pending, with a reply for requester 0 behind it. Required: no reply is delivered to 0 until 1 accepts; no data lost or duplicated.
- Stub core emits a reply with the FIFO empty. Required: reply drained (rdy=1), o_orphan pulses exactly once at its eop, no requester val.
- Assert i_rst for 1 cycle mid-packet in C_FWD with 2 outstanding. Required: all val/rdy=0 next cycle, o_outstanding=0; the next fresh command is granted normally.
